// File: rtl/mips_exec_datapath_pkg.sv
// Shared opcode and ALU-function encodings for the MIPS execute datapath.
package mips_exec_datapath_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_ADDIU = 6'h09,
      OP_SLTI  = 6'h0A,
      OP_SLTIU = 6'h0B,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_XORI  = 6'h0E,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_SRL  = 6'h02,
      FN_SRA  = 6'h03,
      FN_SLLV = 6'h04,
      FN_SRLV = 6'h06,
      FN_SRAV = 6'h07,
      FN_JR   = 6'h08,
      FN_ADDU = 6'h21,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_NOR  = 6'h27,
      FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } alu_fn_e;

endpackage

// File: rtl/mips_exec_datapath_reg_file.sv
// 32x32 register file: two async read ports, one sync write port, r0 hardwired to zero.
module mips_exec_datapath_reg_file
   import mips_exec_datapath_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   ra_addr_i,
   input  logic [AW-1:0]   rb_addr_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic            wr_en_i,
   input  logic [XLEN-1:0] wr_data_i,
   output logic [XLEN-1:0] ra_data_o,
   output logic [XLEN-1:0] rb_data_o,
   output logic [XLEN-1:0] v0_o
);

   logic [XLEN-1:0] regs_q [NREGS];

   // Reset has priority over a same-cycle write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en_i && (wr_addr_i != '0)) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
   assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
   assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_exec_datapath.sv
// Execute-stage datapath: register file, ALU-control decode and a 32-bit combinational ALU.
module mips_exec_datapath
   import mips_exec_datapath_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic [4:0]      shamt,
   input  logic [AW-1:0]   rs_addr,
   input  logic [AW-1:0]   rt_addr,
   input  logic [AW-1:0]   wr_addr,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   input  logic [XLEN-1:0] alu_b,
   output logic [XLEN-1:0] rs_val,
   output logic [XLEN-1:0] rt_val,
   output logic [XLEN-1:0] alu_out,
   output logic [5:0]      alu_fncode,
   output logic [XLEN-1:0] register_v0
);

   mips_exec_datapath_reg_file u_rf (
      .clk       (clk),
      .reset     (reset),
      .ra_addr_i (rs_addr),
      .rb_addr_i (rt_addr),
      .wr_addr_i (wr_addr),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .ra_data_o (rs_val),
      .rb_data_o (rt_val),
      .v0_o      (register_v0)
   );

   // Immediate forms map onto their R-type equivalents; jumps and unknowns add.
   always_comb begin
      alu_fncode = FN_ADDU;
      case (opcode)
         OP_RTYPE:                   alu_fncode = funct;
         OP_ADDIU, OP_LW, OP_SW:     alu_fncode = FN_ADDU;
         OP_ANDI:                    alu_fncode = FN_AND;
         OP_ORI:                     alu_fncode = FN_OR;
         OP_XORI:                    alu_fncode = FN_XOR;
         OP_SLTI:                    alu_fncode = FN_SLT;
         OP_SLTIU:                   alu_fncode = FN_SLTU;
         default:                    alu_fncode = FN_ADDU;
      endcase
   end

   logic [4:0] vsh;
   assign vsh = rs_val[4:0];

   always_comb begin
      alu_out = '0;
      case (alu_fncode)
         FN_ADDU: alu_out = rs_val + alu_b;
         FN_SUBU: alu_out = rs_val - alu_b;
         FN_AND:  alu_out = rs_val & alu_b;
         FN_OR:   alu_out = rs_val | alu_b;
         FN_XOR:  alu_out = rs_val ^ alu_b;
         FN_NOR:  alu_out = ~(rs_val | alu_b);
         FN_SLT:  alu_out = {31'd0, $signed(rs_val) < $signed(alu_b)};
         FN_SLTU: alu_out = {31'd0, rs_val < alu_b};
         FN_SLL:  alu_out = alu_b << shamt;
         FN_SRL:  alu_out = alu_b >> shamt;
         FN_SRA:  alu_out = $unsigned($signed(alu_b) >>> shamt);
         FN_SLLV: alu_out = alu_b << vsh;
         FN_SRLV: alu_out = alu_b >> vsh;
         FN_SRAV: alu_out = $unsigned($signed(alu_b) >>> vsh);
         default: alu_out = '0;
      endcase
   end

endmodule

// File: tb/tb_mips_exec_datapath.sv
// Self-checking bench: directed cases plus randomized ALU and register-file traffic against a reference model.
module tb_mips_exec_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode, funct;
   logic [4:0]  shamt, rs_addr, rt_addr, wr_addr;
   logic        wr_en;
   logic [31:0] wr_data, alu_b;
   logic [31:0] rs_val, rt_val, alu_out, register_v0;
   logic [5:0]  alu_fncode;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_regs [32];

   mips_exec_datapath dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .shamt(shamt),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr), .wr_en(wr_en),
      .wr_data(wr_data), .alu_b(alu_b), .rs_val(rs_val), .rt_val(rt_val),
      .alu_out(alu_out), .alu_fncode(alu_fncode), .register_v0(register_v0)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] m_fncode(logic [5:0] op, logic [5:0] fn);
      case (op)
         6'h00: return fn;
         6'h0C: return 6'h24;
         6'h0D: return 6'h25;
         6'h0E: return 6'h26;
         6'h0A: return 6'h2A;
         6'h0B: return 6'h2B;
         default: return 6'h21;
      endcase
   endfunction

   function automatic logic [31:0] m_alu(logic [5:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         6'h21: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         6'h23: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
         6'h2B: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
         6'h00: return 32'(64'(b) * (64'd1 << sh));
         6'h02: return 32'(64'(b) / (64'd1 << sh));
         6'h03: return 32'(sb >>> sh);
         6'h04: return 32'(64'(b) * (64'd1 << a[4:0]));
         6'h06: return 32'(64'(b) / (64'd1 << a[4:0]));
         6'h07: return 32'(sb >>> a[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
      wr_addr = a; wr_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      if (a != 0) model_regs[a] = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
      tick(); tick();
      reset = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i); rt_addr = 5'(31 - i);
         #1;
         checks++;
         if (rs_val !== 32'd0 || rt_val !== 32'd0) begin
            errors++;
            $display("FAIL reset_read addr=%0d rs=%h rt=%h want 0", i, rs_val, rt_val);
         end
      end
      checks++;
      if (register_v0 !== 32'd0) begin
         errors++; $display("FAIL reset_v0 got %h want 0", register_v0);
      end
   endtask

   task automatic test_reg0_and_v0();
      set_reg(5'd0, 32'hDEAD_BEEF);
      set_reg(5'd2, 32'h1234_5678);
      rs_addr = 5'd0; rt_addr = 5'd0; #1;
      checks++;
      if (rs_val !== 32'd0 || rt_val !== 32'd0) begin
         errors++; $display("FAIL reg0_write rs=%h rt=%h want 0", rs_val, rt_val);
      end
      checks++;
      if (register_v0 !== 32'h1234_5678) begin
         errors++; $display("FAIL v0 got %h want 12345678", register_v0);
      end
      rs_addr = 5'd2; rt_addr = 5'd2; #1;
      checks++;
      if (rs_val !== 32'h1234_5678 || rt_val !== 32'h1234_5678) begin
         errors++; $display("FAIL same_addr rs=%h rt=%h want 12345678", rs_val, rt_val);
      end
   endtask

   task automatic test_directed_alu();
      set_reg(5'd1, 32'hFFFF_FFFF);
      rs_addr = 5'd1;
      opcode = 6'h09; funct = 6'h00; alu_b = 32'h2; #1;
      checks++;
      if (alu_fncode !== 6'h21 || alu_out !== 32'h1) begin
         errors++; $display("FAIL addiu_wrap fn=%h out=%h want 21/00000001", alu_fncode, alu_out);
      end
      opcode = 6'h00; funct = 6'h2A; alu_b = 32'h1; #1;
      checks++;
      if (alu_out !== 32'h1) begin
         errors++; $display("FAIL slt_signed got %h want 1", alu_out);
      end
      funct = 6'h2B; #1;
      checks++;
      if (alu_out !== 32'h0) begin
         errors++; $display("FAIL sltu got %h want 0", alu_out);
      end
      funct = 6'h03; shamt = 5'd4; alu_b = 32'h8000_0000; #1;
      checks++;
      if (alu_out !== 32'hF800_0000) begin
         errors++; $display("FAIL sra got %h want F8000000", alu_out);
      end
      funct = 6'h02; #1;
      checks++;
      if (alu_out !== 32'h0800_0000) begin
         errors++; $display("FAIL srl got %h want 08000000", alu_out);
      end
      funct = 6'h08; #1;
      checks++;
      if (alu_out !== 32'h0) begin
         errors++; $display("FAIL jr_code got %h want 0", alu_out);
      end
      opcode = 6'h03; #1;
      checks++;
      if (alu_fncode !== 6'h21) begin
         errors++; $display("FAIL jal_fncode got %h want 21", alu_fncode);
      end
   endtask

   task automatic test_no_bypass();
      set_reg(5'd5, 32'h33);
      rs_addr = 5'd5; wr_addr = 5'd5; wr_data = 32'd7; wr_en = 1'b1; #1;
      checks++;
      if (rs_val !== 32'h33) begin
         errors++; $display("FAIL no_bypass got %h want 33", rs_val);
      end
      tick();
      wr_en = 1'b0; model_regs[5] = 32'd7;
      checks++;
      if (rs_val !== 32'd7) begin
         errors++; $display("FAIL write_visible got %h want 7", rs_val);
      end
      reset = 1'b1; wr_en = 1'b1; wr_data = 32'd9;
      tick();
      reset = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      checks++;
      if (rs_val !== 32'd0) begin
         errors++; $display("FAIL reset_beats_write got %h want 0", rs_val);
      end
   endtask

   task automatic test_alu_random();
      logic [5:0] ops [12];
      logic [5:0] fns [16];
      logic [31:0] a, ef, eo;
      ops = '{6'h00, 6'h02, 6'h03, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F};
      fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h11};
      for (int n = 0; n < 300; n++) begin
         a = $urandom();
         if (n % 7 == 0) a = 32'h8000_0000 | a[4:0];
         set_reg(5'd1, a);
         rs_addr = 5'd1;
         opcode = (n % 2 == 0) ? 6'h00 : ops[$urandom_range(11)];
         funct  = (n % 9 == 0) ? 6'($urandom()) : fns[$urandom_range(15)];
         shamt  = 5'($urandom());
         alu_b  = $urandom();
         if (n % 5 == 0) alu_b = a;
         #1;
         ef = {26'd0, m_fncode(opcode, funct)};
         eo = m_alu(ef[5:0], a, alu_b, shamt);
         checks++;
         if (alu_fncode !== ef[5:0] || alu_out !== eo) begin
            errors++;
            $display("FAIL alu_rand op=%h fn=%h a=%h b=%h sh=%0d got %h/%h want %h/%h",
                     opcode, funct, a, alu_b, shamt, alu_fncode, alu_out, ef[5:0], eo);
         end
      end
   endtask

   task automatic test_regfile_random();
      logic [31:0] er, et;
      for (int n = 0; n < 400; n++) begin
         rs_addr = 5'($urandom()); rt_addr = (n % 6 == 0) ? rs_addr : 5'($urandom());
         wr_addr = 5'($urandom_range(7)); wr_data = $urandom();
         wr_en = 1'($urandom()); reset = ($urandom_range(39) == 0);
         #1;
         er = model_regs[rs_addr]; et = model_regs[rt_addr];
         checks++;
         if (rs_val !== er || rt_val !== et || register_v0 !== model_regs[2]) begin
            errors++;
            $display("FAIL rf_rand rs[%0d]=%h rt[%0d]=%h v0=%h want %h %h %h",
                     rs_addr, rs_val, rt_addr, rt_val, register_v0, er, et, model_regs[2]);
         end
         tick();
         if (reset) for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
         else if (wr_en && wr_addr != 0) model_regs[wr_addr] = wr_data;
      end
      reset = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      opcode = '0; funct = '0; shamt = '0; rs_addr = '0; rt_addr = '0; alu_b = '0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      tick();
      test_reset();
      test_reg0_and_v0();
      test_directed_alu();
      test_no_bypass();
      test_alu_random();
      test_regfile_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_exec_datapath.md
MIPS_EXEC_DATAPATH -- requirements
Module: mips_exec_datapath

Interface
REQ-001 Parameters: none; data width is fixed at 32 bits and register count at 32.
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26].
REQ-005 funct  input  6  instruction bits [5:0] (R-type function).
REQ-006 shamt  input  5  instruction bits [10:6] (shift amount).
REQ-007 rs_addr  input  5  read port A address.
REQ-008 rt_addr  input  5  read port B address.
REQ-009 wr_addr  input  5  write port address.
REQ-010 wr_en  input  1  register write enable.
REQ-011 wr_data  input  32  register write data.
REQ-012 alu_b  input  32  ALU second operand, selected outside the block (rt_val or the immediate).
REQ-013 rs_val  output  32  register[rs_addr], combinational.
REQ-014 rt_val  output  32  register[rt_addr], combinational.
REQ-015 alu_out  output  32  ALU result of rs_val op alu_b, combinational.
REQ-016 alu_fncode  output  6  decoded ALU operation code.
REQ-017 register_v0  output  32  current content of register 2, combinational.

Function
REQ-018 ALU control is combinational:
- opcode 0x00: alu_fncode = funct.
- 0x09 ADDIU, 0x23 LW, 0x2B SW: 0x21.
- 0x0C ANDI: 0x24.
- 0x0D ORI: 0x25.
- 0x0E XORI: 0x26.
- 0x0A SLTI: 0x2A.
- 0x0B SLTIU: 0x2B.
- All other opcodes, including J 0x02 and JAL 0x03: 0x21.
REQ-019 ALU operations are combinational, 32-bit, with a = rs_val and b = alu_b:
- 0x21 ADDU: a+b modulo 2^32, no overflow flag.
- 0x23 SUBU: a-b modulo 2^32.
- 0x24 AND: a&b.
- 0x25 OR: a|b.
- 0x26 XOR: a^b.
- 0x27 NOR: ~(a|b).
- 0x2A SLT: signed a<b gives 1, otherwise 0.
- 0x2B SLTU: unsigned a<b gives 1, otherwise 0.
- 0x00 SLL: b<<shamt.
- 0x02 SRL: b>>shamt, logical.
- 0x03 SRA: b>>>shamt, arithmetic.
- 0x04 SLLV: b<<a[4:0].
- 0x06 SRLV: b>>a[4:0], logical.
- 0x07 SRAV: b>>>a[4:0], arithmetic.
- Any other code: alu_out = 0.
REQ-020 The ALU has no carry-in; only bits [4:0] of a are used for variable shifts.
REQ-021 The register file holds 32 x 32-bit registers with two asynchronous read ports and one synchronous write port.
REQ-022 When wr_en=1 and reset=0, register[wr_addr] takes wr_data at the rising edge.
REQ-023 Writes to register 0 are ignored; rs_val and rt_val read as 0 whenever their address is 0.
REQ-024 There is no write-to-read bypass: during the write cycle, reads of wr_addr return the old value; the new value is visible after the edge.
REQ-025 register_v0 reflects register 2 after each edge, with the same timing as the read ports.
REQ-026 The two read ports may use the same address and then return identical data.
REQ-027 When reset=1 and wr_en=1 occur together, reset wins and no write takes place.

Reset
REQ-028 At a rising edge with reset=1, all 32 registers are cleared to 0, so rs_val, rt_val and register_v0 are 0 after that edge.
REQ-029 Reset asserted mid-operation overrides any pending write in the same cycle.
REQ-030 The combinational outputs alu_out and alu_fncode have no reset state; they follow their inputs.

Structure
REQ-031 A shared package holds the opcode enum (RTYPE, J, JAL, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LW, SW) and the funct/ALU-code enum (ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR=0x08).
REQ-032 reg_file is the single clocked sub-module and is instantiated once.
REQ-033 The ALU and ALU-control logic are combinational blocks inside mips_exec_datapath.

Verification
REQ-034 Apply reset, then read all 32 addresses -> every rs_val and rt_val is 0, and register_v0 = 0.
REQ-035 Write 0xDEADBEEF to reg 0, then write 0x12345678 to reg 2 -> rs_val(0) = 0 and register_v0 = 0x12345678.
REQ-036 Drive opcode=0x09, rs=0xFFFFFFFF, alu_b=0x00000002 -> alu_fncode = 0x21 and alu_out = 0x00000001 (wraps).
REQ-037 Drive R-type funct=0x2A, rs=0xFFFFFFFF, b=1 -> alu_out = 1; with funct=0x2B -> alu_out = 0.
REQ-038 Drive funct=0x03, shamt=4, b=0x80000000 -> alu_out = 0xF8000000; with funct=0x02 -> alu_out = 0x08000000.
REQ-039 Assert wr_en with wr_addr=rs_addr=5 and wr_data=7 -> rs_val reads the old value that cycle and 7 after the edge; assert reset together with wr_en -> register 5 reads 0.
